// File: rtl/pipe_stage_pkg.sv
// rtl/pipe_stage_pkg.sv - shared sizing helpers and bubble convention for pipe_stage_fifo
package pipe_stage_pkg;

   // A bubble is an all-zero bundle; replicate this bit to the bundle width.
   localparam logic BUBBLE_BIT = 1'b0;

   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic bit depth_ok(input int depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/pipe_stage_mem.sv
// rtl/pipe_stage_mem.sv - falling-edge register array, one write port, one async read port
module pipe_stage_mem
   import pipe_stage_pkg::*;
#(
   parameter int WIDTH = 256,
   parameter int DEPTH = 2,
   parameter int PW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [PW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [PW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(negedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/pipe_stage_fifo.sv
// rtl/pipe_stage_fifo.sv - DEPTH-entry elastic pipeline stage, state on falling clk edge
// Optional same-cycle pass-through when empty: PIPE_STAGE_FIFO_BYPASS_EN.
module pipe_stage_fifo
   import pipe_stage_pkg::*;
#(
   parameter int WIDTH = 256,
   parameter int DEPTH = 2
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            flush,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [WIDTH-1:0]                in_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [WIDTH-1:0]                out_data,
   output logic [count_width(DEPTH)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = count_width(DEPTH);

   if (!depth_ok(DEPTH)) begin : g_depth_check
      $error("pipe_stage_fifo: DEPTH must be a power of two and at least 2");
   end

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] head_data;
   logic             full, empty, stored_valid;
   logic             push, pop, push_st, pop_st;

   assign full         = (count_q == CW'(DEPTH));
   assign empty        = (count_q == '0);
   assign stored_valid = !empty;
   assign in_ready     = !full;
   assign count        = count_q;
   assign push         = in_valid & in_ready;
   assign pop          = out_valid & out_ready;

`ifdef PIPE_STAGE_FIFO_BYPASS_EN
   // An empty stage forwards the incoming bundle; if it is consumed it never touches storage.
   assign out_valid = stored_valid | in_valid;
   assign out_data  = stored_valid ? head_data
                    : (in_valid ? in_data : {WIDTH{BUBBLE_BIT}});
   assign push_st   = push & ~(empty & out_ready);
   assign pop_st    = pop & stored_valid;
`else
   assign out_valid = stored_valid;
   assign out_data  = stored_valid ? head_data : {WIDTH{BUBBLE_BIT}};
   assign push_st   = push;
   assign pop_st    = pop;
`endif

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_st) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_st)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push_st) - CW'(pop_st);
      end
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   pipe_stage_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push_st & ~flush),
      .wr_addr (wr_ptr_q),
      .wr_data (in_data),
      .rd_addr (rd_ptr_q),
      .rd_data (head_data)
   );

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// tb/tb_pipe_stage_fifo.sv - directed vector bench for pipe_stage_fifo (DEPTH=2, WIDTH=32)
module tb_pipe_stage_fifo;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [1:0]    count;

   int checks   = 0;
   int failures = 0;

   pipe_stage_fifo #(.WIDTH(W), .DEPTH(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          fl;
      logic          iv;
      logic [W-1:0]  d;
      logic          rdy;
      logic          ov;
      logic [W-1:0]  od;
      logic [1:0]    cnt;
      logic          ir;
   } vec_t;

   vec_t v [16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // State changes on the falling edge; outputs are sampled just after the rising edge.
   task automatic tick();
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
   endtask

   task automatic check_outputs(input string tag, input logic ov, input logic [W-1:0] od,
                                input logic [1:0] cnt, input logic ir);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'(ov));
      chk({tag, "_out_data"},  64'(out_data),  64'(od));
      chk({tag, "_count"},     64'(count),     64'(cnt));
      chk({tag, "_in_ready"},  64'(in_ready),  64'(ir));
   endtask

   logic prev_ir;

   initial begin
      //        fl    iv    d        rdy   ov    od       cnt   ir
      v[0]  = '{1'b0, 1'b1, 32'hA, 1'b0, 1'b1, 32'hA, 2'd1, 1'b1};
      v[1]  = '{1'b0, 1'b1, 32'hB, 1'b0, 1'b1, 32'hA, 2'd2, 1'b0};
      v[2]  = '{1'b0, 1'b1, 32'hC, 1'b0, 1'b1, 32'hA, 2'd2, 1'b0};
      v[3]  = '{1'b0, 1'b1, 32'hC, 1'b1, 1'b1, 32'hB, 2'd1, 1'b1};
      v[4]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1};
      v[5]  = '{1'b0, 1'b1, 32'h5, 1'b0, 1'b1, 32'h5, 2'd1, 1'b1};
      v[6]  = '{1'b0, 1'b1, 32'h7, 1'b1, 1'b1, 32'h7, 2'd1, 1'b1};
      v[7]  = '{1'b1, 1'b1, 32'h6, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1};
      v[8]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1};
      v[9]  = '{1'b0, 1'b1, 32'h5, 1'b0, 1'b1, 32'h5, 2'd1, 1'b1};
      v[10] = '{1'b1, 1'b1, 32'h6, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1};
      v[11] = '{1'b0, 1'b1, 32'hD, 1'b0, 1'b1, 32'hD, 2'd1, 1'b1};
      v[12] = '{1'b0, 1'b1, 32'hE, 1'b0, 1'b1, 32'hD, 2'd2, 1'b0};
      v[13] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hE, 2'd1, 1'b1};
      v[14] = '{1'b0, 1'b1, 32'hF, 1'b1, 1'b1, 32'hF, 2'd1, 1'b1};
      v[15] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1};

      idle_inputs();
      rst_n = 1'b0;
      #1;
      check_outputs("reset", 1'b0, '0, 2'd0, 1'b1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Table: drive, confirm in_ready was fixed before the edge, step, then check stored state.
      prev_ir = 1'b1;
      for (int i = 0; i < 16; i++) begin
         flush     = v[i].fl;
         in_valid  = v[i].iv;
         in_data   = v[i].d;
         out_ready = v[i].rdy;
         #1;
         chk($sformatf("vec%0d_pre_in_ready", i), 64'(in_ready), 64'(prev_ir));
         tick();
         idle_inputs();
         #1;
         check_outputs($sformatf("vec%0d", i), v[i].ov, v[i].od, v[i].cnt, v[i].ir);
         prev_ir = v[i].ir;
      end

      // Streaming 1..16 with both sides always ready.
      for (int k = 1; k <= 16; k++) begin
         in_valid  = 1'b1;
         out_ready = 1'b1;
         in_data   = W'(k);
         #1;
`ifdef PIPE_STAGE_FIFO_BYPASS_EN
         chk($sformatf("stream%0d_data", k), 64'(out_data), 64'(k));
         chk($sformatf("stream%0d_count", k), 64'(count), 64'd0);
`else
         chk($sformatf("stream%0d_data", k), 64'(out_data), 64'(k - 1));
         chk($sformatf("stream%0d_count", k), 64'(count), (k == 1) ? 64'd0 : 64'd1);
`endif
         tick();
      end
      in_valid = 1'b0;
      in_data  = '0;
      #1;
`ifdef PIPE_STAGE_FIFO_BYPASS_EN
      check_outputs("stream_tail", 1'b0, '0, 2'd0, 1'b1);
`else
      check_outputs("stream_tail", 1'b1, 32'd16, 2'd1, 1'b1);
`endif
      tick();
      idle_inputs();
      #1;
      check_outputs("stream_drained", 1'b0, '0, 2'd0, 1'b1);

      // Empty stage with a consumable input: same-cycle only when bypass is built in.
      in_valid  = 1'b1;
      in_data   = 32'h9;
      out_ready = 1'b1;
      #1;
`ifdef PIPE_STAGE_FIFO_BYPASS_EN
      chk("bypass_same_cycle_valid", 64'(out_valid), 64'd1);
      chk("bypass_same_cycle_data",  64'(out_data),  64'h9);
`else
      chk("bypass_same_cycle_valid", 64'(out_valid), 64'd0);
      chk("bypass_same_cycle_data",  64'(out_data),  64'h0);
`endif
      tick();
      idle_inputs();
      #1;
`ifdef PIPE_STAGE_FIFO_BYPASS_EN
      check_outputs("bypass_after", 1'b0, '0, 2'd0, 1'b1);
`else
      check_outputs("bypass_after", 1'b1, 32'h9, 2'd1, 1'b1);
      out_ready = 1'b1;
      tick();
      idle_inputs();
`endif

      // Asynchronous reset with two entries held.
      in_valid = 1'b1;
      in_data  = 32'h11;
      tick();
      in_data  = 32'h22;
      tick();
      idle_inputs();
      #1;
      check_outputs("prereset_full", 1'b1, 32'h11, 2'd2, 1'b0);
      rst_n = 1'b0;
      #1;
      check_outputs("async_reset", 1'b0, '0, 2'd0, 1'b1);
      tick();
      rst_n = 1'b1;
      tick();
      #1;
      check_outputs("post_reset_idle", 1'b0, '0, 2'd0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
